// File: rtl/mini_cpu_pkg.sv
// Shared Mini-CPU constants and the fetch queue entry type.
package mini_cpu_pkg;

   localparam int WIDTH = 16;
   localparam int DEPTH = 256;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic [AW-1:0]    pc;
      logic [WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// ROM port, decoder handshake, control and debug-read signals of the fetch controller.
// master = fetch controller, slave = ROM/decoder/debug environment.
interface rom_fetch_ctrl_if;
   import mini_cpu_pkg::*;

   logic [AW-1:0]    rom_addr;
   logic [WIDTH-1:0] rom_data;
   logic [WIDTH-1:0] instr;
   logic [AW-1:0]    instr_pc;
   logic             instr_valid;
   logic             instr_ready;
   logic             redirect;
   logic [AW-1:0]    redirect_pc;
   logic             halt;
   logic             dbg_req;
   logic [AW-1:0]    dbg_addr;
   logic             dbg_gnt;
   logic [WIDTH-1:0] dbg_data;
   logic             dbg_valid;

   modport master (
      output rom_addr, instr, instr_pc, instr_valid, dbg_gnt, dbg_data, dbg_valid,
      input  rom_data, instr_ready, redirect, redirect_pc, halt, dbg_req, dbg_addr
   );

   modport slave (
      input  rom_addr, instr, instr_pc, instr_valid, dbg_gnt, dbg_data, dbg_valid,
      output rom_data, instr_ready, redirect, redirect_pc, halt, dbg_req, dbg_addr
   );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; head comes straight from storage.
module fetch_queue
   import mini_cpu_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  fetch_entry_t               entry_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output fetch_entry_t               head_o,
   output logic [$clog2(QDEPTH):0]    count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

   fetch_entry_t  mem_q [QDEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Flush wins over everything; a push into a full queue is only legal alongside a pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push_i && (!full_o || pop_i);
      do_pop   = pop_i && !empty_o;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         do_push  = 1'b0;
         do_pop   = 1'b0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= entry_i;
      end
   end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the ROM and feeds the prefetch queue.
// Define ROM_DBG_PORT_EN to share the ROM port with a debug read requester.
module rom_fetch_ctrl
   import mini_cpu_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input logic              clk,
   input logic              rst,
   rom_fetch_ctrl_if.master bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [AW-1:0] pc_q, pc_d;
   logic          dbg_gnt;
   logic          fetch;
   logic          pop;
   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_head;
   fetch_entry_t  q_entry;

   assign pop     = bus.instr_ready && (q_count != '0);
   assign fetch   = !rst && !bus.redirect && !bus.halt && !dbg_gnt && (!q_full || pop);
   assign q_entry = '{pc: pc_q, instr: bus.rom_data};

   assign bus.rom_addr    = dbg_gnt ? bus.dbg_addr : pc_q;
   assign bus.instr       = q_head.instr;
   assign bus.instr_pc    = q_head.pc;
   assign bus.instr_valid = !q_empty;

   // A redirect always reloads the PC, even while halted or while debug owns the ROM.
   always_comb begin
      pc_d = pc_q;
      if (bus.redirect)  pc_d = bus.redirect_pc;
      else if (fetch)    pc_d = pc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fetch),
      .entry_i (q_entry),
      .pop_i   (pop),
      .flush_i (bus.redirect),
      .head_o  (q_head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

`ifdef ROM_DBG_PORT_EN
   logic             dbg_valid_q;
   logic [WIDTH-1:0] dbg_data_q;

   // The previous grant doubles as the "granted last cycle" flag, so fetch gets every other cycle.
   assign dbg_gnt = !rst && bus.dbg_req && !dbg_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_valid_q <= 1'b0;
         dbg_data_q  <= '0;
      end else begin
         dbg_valid_q <= dbg_gnt;
         if (dbg_gnt) dbg_data_q <= bus.rom_data;
      end
   end

   assign bus.dbg_valid = dbg_valid_q;
   assign bus.dbg_data  = dbg_data_q;
`else
   logic dbg_req_unused;

   assign dbg_req_unused = bus.dbg_req;
   assign dbg_gnt        = 1'b0;
   assign bus.dbg_valid  = 1'b0;
   assign bus.dbg_data   = '0;
`endif

   assign bus.dbg_gnt = dbg_gnt;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: per-cycle vector table, fetch-order scoreboard and debug-port sequence.
// Debug checks follow ROM_DBG_PORT_EN the same way the design does.
module tb_rom_fetch_ctrl;
   import mini_cpu_pkg::*;

   logic clk;
   logic rst;

   rom_fetch_ctrl_if bus ();

   rom_fetch_ctrl #(.QDEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational program ROM contents used by the bench.
   function automatic logic [WIDTH-1:0] romWord(input logic [AW-1:0] a);
      case (a)
         8'h00:   romWord = 16'h1300;
         8'h01:   romWord = 16'h1003;
         8'h02:   romWord = 16'h1004;
         8'h05:   romWord = 16'h1142;
         8'h26:   romWord = 16'h13FF;
         default: romWord = 16'h2000 | {8'h00, a};
      endcase
   endfunction

   assign bus.rom_data = romWord(bus.rom_addr);

   typedef struct {
      logic          rdy;
      logic          halt;
      logic          redir;
      logic [AW-1:0] rpc;
      logic          expValid;
      logic [AW-1:0] expPc;
      logic [AW-1:0] expRa;
   } vec_t;

   vec_t          vecs [27];
   logic [AW-1:0] expQ [$];
   int            compared;
   int            mismatched;

   function automatic vec_t mk(input logic rdy, input logic halt, input logic redir,
                               input logic [AW-1:0] rpc, input logic expValid,
                               input logic [AW-1:0] expPc, input logic [AW-1:0] expRa);
      vec_t v;
      v.rdy = rdy; v.halt = halt; v.redir = redir; v.rpc = rpc;
      v.expValid = expValid; v.expPc = expPc; v.expRa = expRa;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sbRestart(input logic [AW-1:0] start);
      expQ.delete();
      for (int i = 0; i < 64; i++) expQ.push_back(start + AW'(i));
   endtask

   // Every accepted instruction must be the next one in program order.
   task automatic scoreHandshake();
      logic [AW-1:0] p;
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_underflow: got pc 0x%0h, expected no pop", bus.instr_pc);
         end else begin
            p = expQ.pop_front();
            checkOutput("sb_pc", {24'h0, bus.instr_pc}, {24'h0, p});
            checkOutput("sb_instr", {16'h0, bus.instr}, {16'h0, romWord(p)});
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdy, input logic halt,
                                input logic redir, input logic [AW-1:0] rpc);
      rst             = r;
      bus.instr_ready = rdy;
      bus.halt        = halt;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
   endtask

   task automatic toSample();
      @(negedge clk);
   endtask

   task automatic toNextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      bus.dbg_req  = 1'b0;
      bus.dbg_addr = 8'h05;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

      vecs[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
      vecs[1]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 8'h01);
      vecs[2]  = mk(1, 0, 0, 8'h00, 1, 8'h01, 8'h02);
      vecs[3]  = mk(0, 0, 0, 8'h00, 1, 8'h02, 8'h03);
      vecs[4]  = mk(0, 0, 0, 8'h00, 1, 8'h02, 8'h04);
      vecs[5]  = mk(0, 0, 0, 8'h00, 1, 8'h02, 8'h04);
      vecs[6]  = mk(0, 0, 0, 8'h00, 1, 8'h02, 8'h04);
      vecs[7]  = mk(0, 0, 0, 8'h00, 1, 8'h02, 8'h04);
      vecs[8]  = mk(1, 0, 0, 8'h00, 1, 8'h02, 8'h04);
      vecs[9]  = mk(1, 0, 0, 8'h00, 1, 8'h03, 8'h05);
      vecs[10] = mk(1, 0, 0, 8'h00, 1, 8'h04, 8'h06);
      vecs[11] = mk(1, 0, 1, 8'h26, 1, 8'h05, 8'h07);
      vecs[12] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h26);
      vecs[13] = mk(1, 0, 0, 8'h00, 1, 8'h26, 8'h27);
      vecs[14] = mk(0, 0, 0, 8'h00, 1, 8'h27, 8'h28);
      vecs[15] = mk(1, 1, 0, 8'h00, 1, 8'h27, 8'h29);
      vecs[16] = mk(1, 1, 0, 8'h00, 1, 8'h28, 8'h29);
      vecs[17] = mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h29);
      vecs[18] = mk(1, 1, 0, 8'h00, 0, 8'h00, 8'h29);
      vecs[19] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h29);
      vecs[20] = mk(1, 0, 0, 8'h00, 1, 8'h29, 8'h2A);
      vecs[21] = mk(1, 1, 1, 8'hFF, 1, 8'h2A, 8'h2B);
      vecs[22] = mk(1, 1, 0, 8'h00, 0, 8'h00, 8'hFF);
      vecs[23] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'hFF);
      vecs[24] = mk(1, 0, 0, 8'h00, 1, 8'hFF, 8'h00);
      vecs[25] = mk(1, 0, 0, 8'h00, 1, 8'h00, 8'h01);
      vecs[26] = mk(1, 0, 0, 8'h00, 1, 8'h01, 8'h02);

      repeat (3) toNextCycle();
      sbRestart(8'h00);

      for (int i = 0; i < 27; i++) begin
         applyStimulus(1'b0, vecs[i].rdy, vecs[i].halt, vecs[i].redir, vecs[i].rpc);
         toSample();
         checkOutput($sformatf("v%0d_valid", i), {31'h0, bus.instr_valid}, {31'h0, vecs[i].expValid});
         checkOutput($sformatf("v%0d_rom_addr", i), {24'h0, bus.rom_addr}, {24'h0, vecs[i].expRa});
         if (vecs[i].expValid)
            checkOutput($sformatf("v%0d_instr_pc", i), {24'h0, bus.instr_pc}, {24'h0, vecs[i].expPc});
         if (i == 0) begin
            checkOutput("reset_instr", {16'h0, bus.instr}, 32'h0);
            checkOutput("reset_dbg_gnt", {31'h0, bus.dbg_gnt}, 32'h0);
            checkOutput("reset_dbg_valid", {31'h0, bus.dbg_valid}, 32'h0);
            checkOutput("reset_dbg_data", {16'h0, bus.dbg_data}, 32'h0);
         end
         scoreHandshake();
         if (vecs[i].redir) sbRestart(vecs[i].rpc);
         toNextCycle();
      end

      // Reset in the middle of streaming, with the queue holding an entry.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      toSample();
      scoreHandshake();
      sbRestart(8'h00);
      toNextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      toSample();
      checkOutput("midrst_valid", {31'h0, bus.instr_valid}, 32'h0);
      checkOutput("midrst_instr", {16'h0, bus.instr}, 32'h0);
      checkOutput("midrst_instr_pc", {24'h0, bus.instr_pc}, 32'h0);
      checkOutput("midrst_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
      scoreHandshake();
      toNextCycle();
      for (int i = 0; i < 4; i++) begin
         toSample();
         checkOutput($sformatf("postrst%0d_valid", i), {31'h0, bus.instr_valid}, 32'h1);
         scoreHandshake();
         toNextCycle();
      end

      // Debug request held high for eight cycles.
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 8'h05;
      for (int i = 0; i < 8; i++) begin
         toSample();
`ifdef ROM_DBG_PORT_EN
         checkOutput($sformatf("dbg%0d_gnt", i), {31'h0, bus.dbg_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
         checkOutput($sformatf("dbg%0d_valid", i), {31'h0, bus.dbg_valid}, (i % 2 == 1) ? 32'h1 : 32'h0);
         checkOutput($sformatf("dbg%0d_instr_valid", i), {31'h0, bus.instr_valid}, (i % 2 == 0) ? 32'h1 : 32'h0);
         if (i % 2 == 0)
            checkOutput($sformatf("dbg%0d_rom_addr", i), {24'h0, bus.rom_addr}, 32'h05);
         else
            checkOutput($sformatf("dbg%0d_data", i), {16'h0, bus.dbg_data}, 32'h1142);
`else
         checkOutput($sformatf("dbg%0d_gnt", i), {31'h0, bus.dbg_gnt}, 32'h0);
         checkOutput($sformatf("dbg%0d_valid", i), {31'h0, bus.dbg_valid}, 32'h0);
         checkOutput($sformatf("dbg%0d_data", i), {16'h0, bus.dbg_data}, 32'h0);
         checkOutput($sformatf("dbg%0d_instr_valid", i), {31'h0, bus.instr_valid}, 32'h1);
`endif
         scoreHandshake();
         toNextCycle();
      end
      bus.dbg_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toSample();
         scoreHandshake();
         toNextCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
